// File: rtl/control_unit.sv
// Sequencing FSM for the 16-bit bus datapath: latches one instruction per run
// request and drives every bus, register and ALU strobe for one or three steps.
module control_unit #(
  parameter int REG_FIELD_W = 3,
  parameter int OP_W        = 3,
  localparam int N_REGS     = 2 ** REG_FIELD_W,
  localparam int INSTR_W    = OP_W + 2 * REG_FIELD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  output logic               ext_data_en,
  output logic [N_REGS-1:0]  reg_in_en,
  output logic [N_REGS-1:0]  reg_out_en,
  output logic               alu_reg_en,
  output logic               alu_sel,
  output logic               g_reg_en,
  output logic               alu_out_en,
  output logic               done,
  output logic [1:0]         step
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  localparam logic [OP_W-1:0] OP_MV  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MVI = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;

  logic [OP_W-1:0]        op;
  logic [REG_FIELD_W-1:0] rx;
  logic [REG_FIELD_W-1:0] ry;
  logic [N_REGS-1:0]      rx_dec;
  logic [N_REGS-1:0]      ry_dec;
  logic                   op_is_alu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    op        = ir_q[INSTR_W-1 -: OP_W];
    rx        = ir_q[2*REG_FIELD_W-1 -: REG_FIELD_W];
    ry        = ir_q[REG_FIELD_W-1:0];
    rx_dec    = '0;
    ry_dec    = '0;
    rx_dec[rx] = 1'b1;
    ry_dec[ry] = 1'b1;
    op_is_alu = (op == OP_ADD) || (op == OP_SUB);
  end

  // The instruction register only loads in IDLE, so instr is ignored mid-instruction.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          ir_d    = instr;
          state_d = T1;
        end
      end
      T1:      state_d = op_is_alu ? T2 : IDLE;
      T2:      state_d = T3;
      T3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates every strobe so nothing touches the bus while it is held.
  always_comb begin
    ext_data_en = 1'b0;
    reg_in_en   = '0;
    reg_out_en  = '0;
    alu_reg_en  = 1'b0;
    alu_sel     = 1'b0;
    g_reg_en    = 1'b0;
    alu_out_en  = 1'b0;
    done        = 1'b0;
    step        = 2'd0;
    if (!reset) begin
      step = state_q;
      unique case (state_q)
        IDLE: ;
        T1: begin
          if (op == OP_MV) begin
            reg_out_en = ry_dec;
            reg_in_en  = rx_dec;
            done       = 1'b1;
          end else if (op == OP_MVI) begin
            ext_data_en = 1'b1;
            reg_in_en   = rx_dec;
            done        = 1'b1;
          end else if (op_is_alu) begin
            reg_out_en = rx_dec;
            alu_reg_en = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
        T2: begin
          reg_out_en = ry_dec;
          alu_sel    = op[0];
          g_reg_en   = 1'b1;
        end
        T3: begin
          alu_out_en = 1'b1;
          reg_in_en  = rx_dec;
          done       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a small bus/register-file/ALU model
// that lets register results be checked alongside the raw strobes.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [8:0]  instr;
  logic        extDataEn;
  logic [7:0]  regInEn;
  logic [7:0]  regOutEn;
  logic        aluRegEn;
  logic        aluSel;
  logic        gRegEn;
  logic        aluOutEn;
  logic        done;
  logic [1:0]  step;

  logic [15:0] extData;
  logic [15:0] busVal;
  logic [15:0] regs [8];
  logic [15:0] aReg;
  logic [15:0] gReg;
  logic [8:0]  capturedInstr;

  int checksTotal  = 0;
  int checksPassed = 0;

  control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instr       (instr),
    .ext_data_en (extDataEn),
    .reg_in_en   (regInEn),
    .reg_out_en  (regOutEn),
    .alu_reg_en  (aluRegEn),
    .alu_sel     (aluSel),
    .g_reg_en    (gRegEn),
    .alu_out_en  (aluOutEn),
    .done        (done),
    .step        (step)
  );

   always #5 clk = ~clk;

   // Datapath stand-in: the bus carries whichever source is enabled.
   always_comb begin
      busVal = 16'h0000;
      if (extDataEn) busVal = extData;
      for (int i = 0; i < 8; i++)
         if (regOutEn[i]) busVal = regs[i];
      if (aluOutEn) busVal = gReg;
   end

   // Register file, A and G load on the rising edge from the bus.
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++)
         if (regInEn[i]) regs[i] <= busVal;
      if (aluRegEn) aReg <= busVal;
      if (gRegEn)   gReg <= aluSel ? (aReg - busVal) : (aReg + busVal);
   end

   function automatic logic [31:0] packOut(input logic e, input logic [7:0] ri, input logic [7:0] ro,
                                           input logic ar, input logic as, input logic g,
                                           input logic ao, input logic d, input logic [1:0] st);
      return {8'h00, e, ri, ro, ar, as, g, ao, d, st};
   endfunction

   function automatic logic [31:0] observed();
      return packOut(extDataEn, regInEn, regOutEn, aluRegEn, aluSel, gRegEn, aluOutEn, done, step);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checksTotal++;
      if (actual === expected) checksPassed++;
      else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
   endtask

   // Inputs change on the falling edge; outputs are read 1 ns later.
   task automatic applyStimulus(input logic rst, input logic runVal, input logic [8:0] instrVal,
                                input logic [15:0] dataVal);
      @(negedge clk);
      reset   = rst;
      run     = runVal;
      instr   = instrVal;
      extData = dataVal;
      #1;
   endtask

   // mv / mvi: one T1 step, then back to IDLE.
   task automatic doMove(input string tag, input logic [8:0] ins, input logic [15:0] data,
                         input logic [31:0] expT1);
      applyStimulus(0, 1, ins, data);
      checkOutput({tag, "_idle"}, observed(), packOut(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 2'd0));
      applyStimulus(0, 0, 9'h1FF, data);
      checkOutput({tag, "_t1"}, observed(), expT1);
      applyStimulus(0, 0, 9'h000, 16'h0000);
   endtask

   // add / sub with garbage on instr during T1..T3 to show it is ignored.
   task automatic doAddSub(input string tag, input logic [8:0] ins, input logic [7:0] rxOh,
                           input logic [7:0] ryOh, input logic isSub);
      applyStimulus(0, 1, ins, 16'h0000);
      applyStimulus(0, 0, 9'b111_111_111, 16'h0000);
      checkOutput({tag, "_t1"}, observed(), packOut(0, 8'h00, rxOh, 1, 0, 0, 0, 0, 2'd1));
      applyStimulus(0, 0, 9'b001_110_110, 16'h0000);
      checkOutput({tag, "_t2"}, observed(), packOut(0, 8'h00, ryOh, 0, isSub, 1, 0, 0, 2'd2));
      applyStimulus(0, 0, 9'b000_000_000, 16'h0000);
      checkOutput({tag, "_t3"}, observed(), packOut(0, rxOh, 8'h00, 0, 0, 0, 1, 1, 2'd3));
      applyStimulus(0, 0, 9'b000_000_000, 16'h0000);
   endtask

   initial begin
      logic [1:0] expStep [8];
      logic       expDone [8];
      int         drivers;

      expStep = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
      expDone = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
      aReg = 16'h0000;
      gReg = 16'h0000;
      capturedInstr = 9'h000;
      reset = 1'b1; run = 1'b1; instr = 9'b001_011_000; extData = 16'h1111;

      applyStimulus(1, 1, 9'b001_011_000, 16'h1111);
      checkOutput("reset_outputs", observed(), 32'h0);
      applyStimulus(1, 0, 9'h000, 16'h0000);
      checkOutput("reset_hold", observed(), 32'h0);

      // mvi R3,#A5 then mv R1,R3
      doMove("mvi_r3", 9'b001_011_000, 16'h00A5, packOut(1, 8'h08, 8'h00, 0, 0, 0, 0, 1, 2'd1));
      checkOutput("r3_val", {16'h0, regs[3]}, 32'h00A5);
      doMove("mv_r1_r3", 9'b000_001_011, 16'h0000, packOut(0, 8'h02, 8'h08, 0, 0, 0, 0, 1, 2'd1));
      checkOutput("r1_val", {16'h0, regs[1]}, 32'h00A5);
      doMove("mv_r2_r2", 9'b000_010_010, 16'h0000, packOut(0, 8'h04, 8'h04, 0, 0, 0, 0, 1, 2'd1));

      // add then sub R1,R3
      doMove("mvi_r1", 9'b001_001_000, 16'h0005, packOut(1, 8'h02, 8'h00, 0, 0, 0, 0, 1, 2'd1));
      doAddSub("add_r1_r3", 9'b010_001_011, 8'h02, 8'h08, 1'b0);
      checkOutput("add_result", {16'h0, regs[1]}, 32'h00AA);
      doAddSub("sub_r1_r3", 9'b011_001_011, 8'h02, 8'h08, 1'b1);
      checkOutput("sub_result", {16'h0, regs[1]}, 32'h0005);

      // 0 - 1 wraps to FFFF
      doMove("mvi_r3_1", 9'b001_011_000, 16'h0001, packOut(1, 8'h08, 8'h00, 0, 0, 0, 0, 1, 2'd1));
      doMove("mvi_r1_0", 9'b001_001_000, 16'h0000, packOut(1, 8'h02, 8'h00, 0, 0, 0, 0, 1, 2'd1));
      doAddSub("sub_wrap", 9'b011_001_011, 8'h02, 8'h08, 1'b1);
      checkOutput("wrap_result", {16'h0, regs[1]}, 32'hFFFF);

      // Reset in T2 of an add abandons it
      doMove("mvi_r1_1234", 9'b001_001_000, 16'h1234, packOut(1, 8'h02, 8'h00, 0, 0, 0, 0, 1, 2'd1));
      applyStimulus(0, 1, 9'b010_001_011, 16'h0000);
      applyStimulus(0, 0, 9'h000, 16'h0000);
      checkOutput("abort_t1", observed(), packOut(0, 8'h00, 8'h02, 1, 0, 0, 0, 0, 2'd1));
      applyStimulus(1, 0, 9'h000, 16'h0000);
      checkOutput("abort_reset_t2", observed(), 32'h0);
      applyStimulus(0, 0, 9'h000, 16'h0000);
      checkOutput("abort_idle", observed(), 32'h0);
      applyStimulus(0, 0, 9'h000, 16'h0000);
      checkOutput("abort_no_done", observed(), 32'h0);
      checkOutput("abort_r1_kept", {16'h0, regs[1]}, 32'h1234);

      // run held high: mvi R4,#7; add R4,R4; reserved
      applyStimulus(0, 1, 9'b001_100_000, 16'h0007);
      for (int c = 1; c <= 8; c++) begin
         if (c == 1)      applyStimulus(0, 1, 9'b010_100_100, 16'h0007);
         else if (c == 5) applyStimulus(0, 1, 9'b111_000_000, 16'h0007);
         else if (c >= 7) applyStimulus(0, 0, 9'b111_000_000, 16'h0007);
         else             applyStimulus(0, 1, instr, 16'h0007);
         checkOutput($sformatf("burst_step_c%0d", c), {30'h0, step}, {30'h0, expStep[c-1]});
         checkOutput($sformatf("burst_done_c%0d", c), {31'h0, done}, {31'h0, expDone[c-1]});
         if (c == 7)
            checkOutput("reserved_no_strobes", observed(), packOut(0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 2'd1));
      end
      checkOutput("burst_r4", {16'h0, regs[4]}, 32'h000E);

      // Random stream: bus exclusivity, one-hot rules, instr latched only in IDLE
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), 9'($urandom), 16'($urandom));
         drivers = int'(extDataEn) + int'(aluOutEn) + $countones(regOutEn);
         checkOutput("rand_bus_drivers", {31'h0, drivers <= 1}, 32'h1);
         checkOutput("rand_onehot", {30'h0, $onehot0(regInEn), $onehot0(regOutEn)}, 32'h3);
         if (step != 2'd2) checkOutput("rand_alu_sel", {31'h0, aluSel}, 32'h0);
         if (done)
            checkOutput("rand_done_dest", {24'h0, regInEn},
                        capturedInstr[8] ? 32'h0 : {24'h0, 8'(8'h01 << capturedInstr[5:3])});
         if (step == 2'd0 && run) capturedInstr = instr;
      end

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
